tick_gen_multi: RTL

- Parametrised multi-channel tick generator replacing single fixed-rate dividers.
- Each channel counts system clocks and emits a one-cycle tick pulse plus a 50%-style toggle output every P cycles.
- Each channel's period P is run-time programmable through a simple write port.
- Feeds display shifting, LED blink and timeout logic in the authentication top level from one shared block.

---
 rtl/tick_gen_pkg.sv | 8 +
 rtl/tick_chan.sv | 46 ++++
 rtl/tick_gen_multi.sv | 37 +++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults and index-width helper for the tick generator
package tick_gen_pkg;
  localparam int DEF_CNT_W = 26;
  localparam int DEF_PERIOD = 50_000_000;
  function automatic int ch_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one programmable-period counter producing a tick pulse and a toggle
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(DEF_PERIOD)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  output logic             tick,
  output logic             tog,
  output logic             busy
);
  logic [CNT_W-1:0] ct;
  logic [CNT_W-1:0] period;
  assign busy = period != '0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ct <= '0;
      period <= DEFAULT_PERIOD;
      tick <= 1'b0;
      tog <= 1'b0;
    end else if (wr) begin
      period <= wr_period;
      ct <= '0;
      tick <= 1'b0;
    end else if (sync_clr) begin
      ct <= '0;
      tick <= 1'b0;
      tog <= 1'b0;
    end else if (!en || !busy) begin
      tick <= 1'b0;
    end else if (ct == period - 1'b1) begin
      ct <= '0;
      tick <= 1'b1;
      tog <= ~tog;
    end else begin
      ct <= ct + 1'b1;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH independent tick channels with a shared period write port
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD,
  localparam int IW = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] tog_o,
  output logic [NUM_CH-1:0] busy_o
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_chan #(
      .CNT_W(CNT_W),
      .DEFAULT_PERIOD(CNT_W'(DEFAULT_PERIOD))
    ) u_chan (
      .clk(clk),
      .rstn(rstn),
      .en(en),
      .sync_clr(sync_clr),
      .wr(cfg_we && cfg_ch == IW'(g)),
      .wr_period(cfg_period),
      .tick(tick_o[g]),
      .tog(tog_o[g]),
      .busy(busy_o[g])
    );
  end
endmodule
